dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
//  Parametrised byte-addressed RV32 data memory with a valid/ready request port and a registered response.
//  Supports LB/LH/LW/LBU/LHU/SB/SH/SW via funct3, with byte-lane stores and sign/zero-extended loads.
//  Flags misaligned/out-of-range/illegal accesses and self-clears its array after every reset.
//  Sits between the core's MEM stage and the word array; successor to the single-word data memory.
// PARAMETERS
//  DEPTH   64  number of 32-bit words (power of 2, >=2)
//  AW      $clog2(DEPTH)  word-index width (localparam, derived)
// PORTS
//  clk        in   1   rising-edge clock, the only clock
//  rst_n      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   block can accept request this cycle
//  req_we     in   1   1=store, 0=load
//  req_funct3 in   3   RV32 width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data (rs2), LSB-aligned
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   consumer accepts response
//  rsp_rdata  out  32  load result, extended; 0 for stores and errors
//  rsp_err    out  1   access rejected (qualified by rsp_valid)
//  init_done  out  1   array clear complete
// BEHAVIOUR
//  Reset (async assert, sync release): state=INIT, clr_idx=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, req_ready=0.
//  FSM INIT: write 0 to word clr_idx each cycle; clr_idx==DEPTH-1 -> RUN, init_done=1 next cycle. DEPTH cycles total.
//  FSM RUN: stays until reset. No other states.
//  req_ready = (state==RUN) && (!rsp_valid || rsp_ready); combinational.
//  Accept = req_valid && req_ready. Request ignored when not accepted (no side effects).
//  Index = req_addr[AW+1:2]. Out-of-range: any req_addr[31:AW+2] != 0.
//  Error if: out-of-range; H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3[2]=1.
//  Erroring access: no array write, rsp_err=1, rsp_rdata=0.
//  Store: on accept edge, write byte lanes only: SB lane addr[1:0] <- wdata[7:0]; SH lanes {addr[1],0}+1..0 <- wdata[15:0]; SW all.
//  Load: array read registered on accept edge; B/H sign-extend, BU/HU zero-extend from the addressed lane(s).
//  Latency: response rsp_valid=1 on cycle after accept, for loads and stores alike.
//  Response held stable (rdata, err) while rsp_valid && !rsp_ready; cleared to rsp_valid=0 on rsp_ready with no new accept.
//  Back-to-back: rsp_ready=1 with new accept -> new response replaces old next cycle, full throughput 1/cycle.
//  Store then load same word on consecutive accepts: load returns the new data (write lands on first edge).
//  Wrap-around: none; addresses above array size are errors, never aliased.
//  Reset mid-operation: pending response dropped, array re-cleared, any in-flight store may or may not have landed (cleared anyway).
//  No X on outputs after reset; array contents are don't-care until init_done.
// STRUCTURE
//  dmem_pkg: funct3 localparams (F3_B..F3_HU), state encoding (ST_INIT, ST_RUN), error-check function.
//  Sub-module dmem_lane_fmt (combinational): store byte-enable/alignment + load extract/extend.
//  Top holds FSM, clear counter, word array (reg [31:0] mem[0:DEPTH-1]), response register.
// TESTING
//  1 Reset release, DEPTH=64 -> req_ready=0 for 64 cycles, init_done=1 after; LW 0x00 returns 0.
//  2 SW 0x20 wdata=0xDEADBEEF; LW 0x20 -> 0xDEADBEEF; LB 0x23 -> 0xFFFFFFDE; LBU 0x21 -> 0x000000BE; LH 0x22 -> 0xFFFFDEAD.
//  3 SB 0x21 wdata=0x55 over 0xDEADBEEF; LW 0x20 -> 0xDEAD55EF; SH 0x22 wdata=0x1234 -> LW 0xDEAD55EF becomes 0x123455EF.
//  4 LW 0x22, SH 0x01, LW 0x100 (DEPTH=64), funct3=011 -> rsp_err=1, rdata=0, word unchanged.
//  5 rsp_ready=0 for 3 cycles after load -> rsp held, req_ready=0; then rsp_ready=1 with SW+LW back-to-back -> 1 rsp/cycle.
//  6 Assert rst_n=0 mid-stream with rsp_valid=1 -> rsp_valid=0 immediately; after re-init, previously stored word reads 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 codes, controller states and the access legality check for dmem_ctrl.
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Halfword codes share funct3[1:0]=01, word is 010; 110/111/011 are illegal outright.
  function automatic logic acc_err(input logic we, input logic [2:0] f3,
                                   input logic [1:0] a, input logic oor);
    logic bad_f3;
    bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    return oor || bad_f3 || (we && f3[2]) ||
           ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction
endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: store byte enables/lane replication and load lane extract with sign/zero extension.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    o_be    = (i_funct3[1:0] == 2'b00) ? 4'b0001 << i_addr_lo :
              (i_funct3[1:0] == 2'b01) ? (i_addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    o_wdata = (i_funct3[1:0] == 2'b00) ? {4{i_wdata[7:0]}} :
              (i_funct3[1:0] == 2'b01) ? {2{i_wdata[15:0]}} : i_wdata;
    o_rdata = (i_funct3 == F3_B)  ? {{24{w_byte[7]}}, w_byte} :
              (i_funct3 == F3_BU) ? {24'b0, w_byte} :
              (i_funct3 == F3_H)  ? {{16{w_half[15]}}, w_half} :
              (i_funct3 == F3_HU) ? {16'b0, w_half} : i_rword;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed RV32 data memory with valid/ready requests, registered response
// and an array self-clear after every reset.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);
  localparam int AW = $clog2(DEPTH);

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_clr_idx;
  logic [31:0]     r_mem [0:DEPTH-1];
  logic            r_rsp_valid, r_rsp_err;
  logic [31:0]     r_rsp_rdata;
  logic [AW-1:0]   w_idx;
  logic            w_oor, w_err, w_accept, w_wr;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata, w_ld;

  assign w_oor     = |req_addr[31:AW+2];
  assign w_idx     = req_addr[AW+1:2];
  assign w_err     = acc_err(req_we, req_funct3, req_addr[1:0], w_oor);
  assign req_ready = (r_state == ST_RUN) && (!r_rsp_valid || rsp_ready);
  assign w_accept  = req_valid && req_ready;
  assign w_wr      = w_accept && req_we && !w_err;
  assign init_done = (r_state == ST_RUN);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  dmem_lane_fmt u_fmt (
    .i_funct3 (req_funct3),
    .i_addr_lo(req_addr[1:0]),
    .i_wdata  (req_wdata),
    .i_rword  (r_mem[w_idx]),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_rdata  (w_ld)
  );

  always_comb begin
    w_state_nxt = (r_state == ST_INIT && r_clr_idx == AW'(DEPTH - 1)) ? ST_RUN : r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= (r_state == ST_INIT) ? r_clr_idx + 1'b1 : r_clr_idx;
    end
  end

  // No reset on the array itself; the INIT sweep zeroes one word per cycle.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT)
      r_mem[r_clr_idx] <= '0;
    else if (w_wr)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= (w_err || req_we) ? '0 : w_ld;
      r_rsp_err   <= w_err;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed table of single requests plus hand-written stall, back-to-back
// and mid-stream reset sequences for dmem_ctrl (DEPTH=64).
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err, init_done;
  logic [31:0] rsp_rdata;
  int          checks = 0, errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t v[22];

  dmem_ctrl #(.DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
  endtask

  // Entered at a negedge; response is checked one cycle later, leaving req_valid low.
  task automatic apply(input vec_t t, input string name);
    drive(t.we, t.f3, t.addr, t.wdata);
    @(negedge clk);
    chk({name, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({name, ".rdata"}, rsp_rdata, t.rdata);
    chk({name, ".err"}, 32'(rsp_err), 32'(t.err));
    req_valid = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    v[0]  = '{1'b0, 3'b010, 32'h00, 32'h0, 32'h00000000, 1'b0};
    v[1]  = '{1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0};
    v[2]  = '{1'b0, 3'b010, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0};
    v[3]  = '{1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFFFFDE, 1'b0};
    v[4]  = '{1'b0, 3'b100, 32'h21, 32'h0, 32'h000000BE, 1'b0};
    v[5]  = '{1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFDEAD, 1'b0};
    v[6]  = '{1'b1, 3'b000, 32'h21, 32'h55, 32'h0, 1'b0};
    v[7]  = '{1'b0, 3'b010, 32'h20, 32'h0, 32'hDEAD55EF, 1'b0};
    v[8]  = '{1'b1, 3'b001, 32'h22, 32'h1234, 32'h0, 1'b0};
    v[9]  = '{1'b0, 3'b010, 32'h20, 32'h0, 32'h123455EF, 1'b0};
    v[10] = '{1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1};
    v[11] = '{1'b1, 3'b001, 32'h21, 32'hFFFF, 32'h0, 1'b1};
    v[12] = '{1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1};
    v[13] = '{1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1};
    v[14] = '{1'b1, 3'b100, 32'h20, 32'h0, 32'h0, 1'b1};
    v[15] = '{1'b0, 3'b010, 32'h20, 32'h0, 32'h123455EF, 1'b0};
    v[16] = '{1'b0, 3'b101, 32'h22, 32'h0, 32'h00001234, 1'b0};
    v[17] = '{1'b0, 3'b000, 32'h21, 32'h0, 32'h00000055, 1'b0};
    v[18] = '{1'b1, 3'b010, 32'hFC, 32'hA5A5A5A5, 32'h0, 1'b0};
    v[19] = '{1'b0, 3'b010, 32'hFC, 32'h0, 32'hA5A5A5A5, 1'b0};
    v[20] = '{1'b1, 3'b000, 32'h101, 32'hFF, 32'h0, 1'b1};
    v[21] = '{1'b0, 3'b010, 32'h00, 32'h0, 32'h00000000, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.init_done", 32'(init_done), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    wait_init(n);
    chk("init.cycles", 32'(n), 32'd64);
    chk("init.done", 32'(init_done), 32'd1);

    for (int i = 0; i < 22; i++) apply(v[i], $sformatf("vec%0d", i));
    @(negedge clk);
    chk("idle.rsp_valid", 32'(rsp_valid), 32'd0);

    // Stall: load accepted with rsp_ready low, a store offered during the stall is ignored.
    rsp_ready = 1'b0;
    drive(1'b0, 3'b010, 32'hFC, 32'h0);
    @(negedge clk);
    drive(1'b1, 3'b010, 32'hFC, 32'h11111111);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d.valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall%0d.rdata", i), rsp_rdata, 32'hA5A5A5A5);
      chk($sformatf("stall%0d.ready", i), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("b2b.sw.valid", 32'(rsp_valid), 32'd1);
    chk("b2b.sw.rdata", rsp_rdata, 32'd0);
    drive(1'b0, 3'b010, 32'hFC, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b.lw.valid", 32'(rsp_valid), 32'd1);
    chk("b2b.lw.rdata", rsp_rdata, 32'h11111111);
    @(negedge clk);
    chk("b2b.drain", 32'(rsp_valid), 32'd0);

    // Reset while a response is pending.
    drive(1'b0, 3'b010, 32'h20, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst.valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst.init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n);
    chk("reinit.cycles", 32'(n), 32'd64);
    apply('{1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0}, "reinit.w20");
    apply('{1'b0, 3'b010, 32'hFC, 32'h0, 32'h0, 1'b0}, "reinit.wFC");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
